// File: rtl/dm_pkg.sv
// Shared encodings for the dm_ext data memory: access ops, FSM states, op legality.
package dm_pkg;

    typedef enum logic [2:0] {
        OP_W  = 3'b000,
        OP_HU = 3'b001,
        OP_HS = 3'b010,
        OP_BU = 3'b011,
        OP_BS = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_BS);
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic: store merge into the old word, load extract/extend, alignment check.
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] ldata,
    output logic        misaligned
);

    logic [15:0] half;
    logic [7:0]  bsel;

    always_comb begin
        merged     = old_word;
        ldata      = '0;
        misaligned = 1'b0;
        half       = lane[1] ? old_word[31:16] : old_word[15:0];
        bsel       = old_word[{lane, 3'b000} +: 8];
        case (op)
            OP_W: begin
                merged     = wdata;
                ldata      = old_word;
                misaligned = (lane != 2'b00);
            end
            OP_HU, OP_HS: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
                ldata      = (op == OP_HS) ? {{16{half[15]}}, half} : {16'h0000, half};
                misaligned = lane[0];
            end
            OP_BU, OP_BS: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                ldata = (op == OP_BS) ? {{24{bsel[7]}}, bsel} : {24'h000000, bsel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_ext.sv
// Data memory with sub-word access, range/alignment checks, post-reset clear and
// configurable access latency behind a valid/ready request handshake.
module dm_ext
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        exc
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_t         state;
    logic [IW-1:0]  clr_idx;
    logic [CW-1:0]  cnt;
    logic [31:0]    l_pc, l_addr, l_wdata;
    logic           l_we;
    logic [2:0]     l_op;

    logic [31:0] s_pc, s_addr, s_wdata;
    logic        s_we;
    logic [2:0]  s_op;
    logic [29:0] word_off;
    logic [IW-1:0] widx;
    logic        oor, misaligned, bad, fire;
    logic [31:0] old_word, merged, ldata;

    // With LATENCY=1 the access executes on the accepting edge, straight from the ports.
    always_comb begin
        s_pc     = (state == IDLE) ? pc      : l_pc;
        s_addr   = (state == IDLE) ? addr    : l_addr;
        s_wdata  = (state == IDLE) ? wdata   : l_wdata;
        s_we     = (state == IDLE) ? req_we  : l_we;
        s_op     = (state == IDLE) ? req_op  : l_op;
        word_off = 30'((s_addr - BASE_ADDR) >> 2);
        widx     = word_off[IW-1:0];
        oor      = (s_addr < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));
        old_word = oor ? 32'h0 : mem[widx];
        bad      = oor || misaligned || !op_legal(s_op);
        fire     = ((state == IDLE) && req_valid && (LATENCY == 1))
                || ((state == WAIT) && (cnt == CW'(1)));
    end

    dm_lane u_lane (
        .op         (s_op),
        .lane       (s_addr[1:0]),
        .old_word   (old_word),
        .wdata      (s_wdata),
        .merged     (merged),
        .ldata      (ldata),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            exc        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            rdata      <= '0;
            exc        <= 1'b0;
            case (state)
                CLEAR: begin
                    mem[clr_idx] <= '0;
                    if (clr_idx == IW'(DEPTH_WORDS - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        l_pc    <= pc;
                        l_we    <= req_we;
                        l_op    <= req_op;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        if (LATENCY > 1) begin
                            state     <= WAIT;
                            req_ready <= 1'b0;
                            cnt       <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase

            if (fire) begin
                resp_valid <= 1'b1;
                if (bad) begin
                    exc <= 1'b1;
                end else if (s_we) begin
                    mem[widx] <= merged;
                    $display("%d@%h: *%h <= %h", $time, s_pc, {s_addr[31:2], 2'b00}, merged);
                end else begin
                    rdata <= ldata;
                end
            end
        end
    end

endmodule
